// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB, decode read, CP0 and debug trace signals of the writeback stage
interface wb_regfile_if;
   logic        mem_stall;
   logic        memwb_mem_r;
   logic        memwb_reg_w;
   logic [3:0]  reg_byte_w_en;
   logic [4:0]  memwb_rd_addr;
   logic [31:0] memwb_memdata;
   logic [31:0] memwb_exdata;
   logic [31:0] aligned_rt_data;
   logic [4:0]  memwb_cp0_dst_addr;
   logic        memwb_cp0_w_en;
   logic [31:0] memwb_inst;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        cp0_w_en;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [31:0] retire_cnt;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   modport master (
      output mem_stall, memwb_mem_r, memwb_reg_w, reg_byte_w_en, memwb_rd_addr,
             memwb_memdata, memwb_exdata, aligned_rt_data, memwb_cp0_dst_addr,
             memwb_cp0_w_en, memwb_inst, rs_addr, rt_addr,
      input  rs_data, rt_data, cp0_w_en, cp0_waddr, cp0_wdata, retire_cnt,
             debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
   );

   modport slave (
      input  mem_stall, memwb_mem_r, memwb_reg_w, reg_byte_w_en, memwb_rd_addr,
             memwb_memdata, memwb_exdata, aligned_rt_data, memwb_cp0_dst_addr,
             memwb_cp0_w_en, memwb_inst, rs_addr, rt_addr,
      output rs_data, rt_data, cp0_w_en, cp0_waddr, cp0_wdata, retire_cnt,
             debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
   );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage with byte-lane merge, bypassed 32x32 GPR file and exactly-once commit
module wb_regfile (
   input  logic        clk,
   input  logic        resetn,
   wb_regfile_if.slave bus
);
   logic [31:0] gpr [1:31];
   logic        committed;
   logic [31:0] cnt;
   logic        fire;
   logic        wr;
   logic [31:0] base;
   logic [31:0] wdata;

   // an instruction held by a stall was already committed on its first cycle
   assign fire = resetn & ~committed;
   assign base = bus.memwb_mem_r ? bus.memwb_memdata : bus.memwb_exdata;
   assign wr   = fire & bus.memwb_reg_w & (|bus.memwb_rd_addr) & (|bus.reg_byte_w_en);

   // byte-lane merge: unwritten lanes keep the rt value so LWL/LWR write a full word
   always_comb begin
      wdata = bus.aligned_rt_data;
      for (int k = 0; k < 4; k++)
         if (bus.reg_byte_w_en[k]) wdata[8*k +: 8] = base[8*k +: 8];
   end

   // read ports: $0 is hardwired, a same-cycle write is forwarded ahead of the array
   always_comb begin
      bus.rs_data = ~|bus.rs_addr ? 32'h0 :
                    (wr && bus.rs_addr == bus.memwb_rd_addr) ? wdata : gpr[bus.rs_addr];
      bus.rt_data = ~|bus.rt_addr ? 32'h0 :
                    (wr && bus.rt_addr == bus.memwb_rd_addr) ? wdata : gpr[bus.rt_addr];
   end

   assign bus.cp0_w_en          = fire & bus.memwb_cp0_w_en;
   assign bus.cp0_waddr         = bus.memwb_cp0_dst_addr;
   assign bus.cp0_wdata         = bus.aligned_rt_data;
   assign bus.retire_cnt        = cnt;
   assign bus.debug_wb_rf_wen   = wr ? bus.reg_byte_w_en : 4'b0;
   assign bus.debug_wb_rf_wnum  = bus.memwb_rd_addr;
   assign bus.debug_wb_rf_wdata = wdata;

   // register file: cleared on reset, written once per committed instruction
   always_ff @(posedge clk) begin
      if (!resetn)
         for (int k = 1; k < 32; k++) gpr[k] <= 32'h0;
      else if (wr)
         gpr[bus.memwb_rd_addr] <= wdata;
   end

   // commit tracking and retired-instruction counter (bubbles do not count)
   always_ff @(posedge clk) begin
      if (!resetn) begin
         committed <= 1'b0;
         cnt       <= 32'h0;
      end else begin
         committed <= bus.mem_stall;
         if (fire && |bus.memwb_inst) cnt <= cnt + 32'h1;
      end
   end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for the writeback stage and register file
module tb_wb_regfile;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   wb_regfile_if bus();
   wb_regfile dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

   always #5 clk = ~clk;

   localparam int RS = 0, RT = 1, CPW = 2, CPA = 3, CPD = 4, RET = 5, WEN = 6, WNUM = 7, WDAT = 8;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mgpr [32];
   logic [31:0] mcnt;
   logic        mcomm;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want_v);
      n_cmp++;
      if (got !== want_v) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, want_v);
      end
   endtask

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         RS:      return bus.rs_data;
         RT:      return bus.rt_data;
         CPW:     return {31'h0, bus.cp0_w_en};
         CPA:     return {27'h0, bus.cp0_waddr};
         CPD:     return bus.cp0_wdata;
         RET:     return bus.retire_cnt;
         WEN:     return {28'h0, bus.debug_wb_rf_wen};
         WNUM:    return {27'h0, bus.debug_wb_rf_wnum};
         WDAT:    return bus.debug_wb_rf_wdata;
         default: return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic want(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = v;
      sb.push_back(e);
   endtask

   // compare everything queued for this cycle mid-cycle, then move just past the next edge
   task automatic tick();
      exp_t e;
      @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, obs(e.sel), e.val);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mr, input logic rw, input logic [3:0] be, input logic [4:0] rd,
                        input logic [31:0] md, input logic [31:0] ed, input logic [31:0] rt,
                        input logic [4:0] cdst, input logic cw, input logic [31:0] inst,
                        input logic stall);
      bus.memwb_mem_r        = mr;
      bus.memwb_reg_w        = rw;
      bus.reg_byte_w_en      = be;
      bus.memwb_rd_addr      = rd;
      bus.memwb_memdata      = md;
      bus.memwb_exdata       = ed;
      bus.aligned_rt_data    = rt;
      bus.memwb_cp0_dst_addr = cdst;
      bus.memwb_cp0_w_en     = cw;
      bus.memwb_inst         = inst;
      bus.mem_stall          = stall;
   endtask

   task automatic bubble();
      drive(0, 0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0);
   endtask

   task automatic rd_at(input logic [4:0] rs, input logic [4:0] rt);
      bus.rs_addr = rs;
      bus.rt_addr = rt;
   endtask

   logic        rmr, rrw, rcw, stl, pstl, fire, wr;
   logic [3:0]  rbe;
   logic [4:0]  rrd, rcd, rsa;
   logic [31:0] rmd, red, rrt, rinst, base, wd, ers;

   initial begin
      // reset: a would-be write and CP0 strobe must be masked
      resetn = 1'b0;
      drive(0, 1, 4'hF, 5'd3, 32'h0, 32'h0000_CAFE, 32'h0, 5'd4, 1, 32'h1, 0);
      rd_at(5'd3, 5'd0);
      want("rst_cp0", CPW, 0);
      want("rst_wen", WEN, 0);
      want("rst_byp", RS, 0);
      tick();
      tick();
      resetn = 1'b1;
      bubble();
      rd_at(5'd3, 5'd0);
      want("rst_gpr3", RS, 0);
      want("rst_ret", RET, 0);
      tick();

      // ALU write with same-cycle bypass, then from the array
      drive(0, 1, 4'hF, 5'd5, 32'h0, 32'h1234_5678, 32'h0, 5'd0, 0, 32'h1, 0);
      rd_at(5'd5, 5'd0);
      want("alu_byp", RS, 32'h1234_5678);
      want("alu_rt0", RT, 0);
      want("alu_wen", WEN, 4'hF);
      want("alu_wnum", WNUM, 5);
      want("alu_ret0", RET, 0);
      tick();
      bubble();
      rd_at(5'd5, 5'd0);
      want("alu_gpr", RS, 32'h1234_5678);
      want("alu_ret1", RET, 1);
      tick();

      // LWL-style merge of upper two lanes over rt
      drive(1, 1, 4'b1100, 5'd7, 32'hAABB_CCDD, 32'h5555_5555, 32'h1122_3344, 5'd0, 0, 32'h2, 0);
      rd_at(5'd0, 5'd7);
      want("lwl_wdata", WDAT, 32'hAABB_3344);
      want("lwl_wen", WEN, 4'b1100);
      want("lwl_byp", RT, 32'hAABB_3344);
      tick();
      bubble();
      rd_at(5'd5, 5'd7);
      want("lwl_gpr7", RT, 32'hAABB_3344);
      want("lwl_gpr5", RS, 32'h1234_5678);
      want("lwl_ret", RET, 2);
      tick();

      // MTC0 held by a 3-cycle stall: one strobe, one retire
      drive(0, 0, 4'h0, 5'd0, 32'h0, 32'h0, 32'hDEAD_0001, 5'd12, 1, 32'h3, 1);
      want("mtc0_en", CPW, 1);
      want("mtc0_addr", CPA, 12);
      want("mtc0_data", CPD, 32'hDEAD_0001);
      want("mtc0_ret0", RET, 2);
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) bus.mem_stall = 1'b0;
         want($sformatf("mtc0_hold%0d", i), CPW, 0);
         want($sformatf("mtc0_ret%0d", i + 1), RET, 3);
         tick();
      end

      // GPR write held one extra cycle: traced once, then served from the array
      drive(0, 1, 4'hF, 5'd9, 32'h0, 32'h9999_0000, 32'h0, 5'd0, 0, 32'h5, 1);
      rd_at(5'd9, 5'd0);
      want("stw_wen", WEN, 4'hF);
      want("stw_byp", RS, 32'h9999_0000);
      tick();
      bus.mem_stall = 1'b0;
      want("stw_hold_wen", WEN, 0);
      want("stw_hold_rs", RS, 32'h9999_0000);
      want("stw_ret", RET, 4);
      tick();

      // write to $0 has no effect but still retires
      drive(0, 1, 4'hF, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 0, 32'h6, 0);
      rd_at(5'd0, 5'd0);
      want("r0_rs", RS, 0);
      want("r0_wen", WEN, 0);
      tick();

      // reg_w with no lanes enabled is not a write
      drive(0, 1, 4'h0, 5'd10, 32'h0, 32'h0000_0077, 32'h0, 5'd0, 0, 32'h7, 0);
      rd_at(5'd10, 5'd0);
      want("be0_rs", RS, 0);
      want("be0_wen", WEN, 0);
      want("be0_wnum", WNUM, 10);
      want("r0_ret", RET, 5);
      tick();
      bubble();
      rd_at(5'd10, 5'd0);
      want("be0_gpr", RS, 0);
      tick();

      // bubble stream leaves the counter alone
      for (int i = 0; i < 10; i++) begin
         bubble();
         if (i == 9) want("bub_ret", RET, 6);
         tick();
      end

      // reset in the middle of a stall
      drive(0, 1, 4'hF, 5'd11, 32'h0, 32'hB0B0_B0B0, 32'h0, 5'd0, 0, 32'h8, 1);
      want("mid_wen", WEN, 4'hF);
      tick();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      drive(0, 1, 4'hF, 5'd12, 32'h0, 32'h1212_1212, 32'h0, 5'd0, 0, 32'h9, 1);
      rd_at(5'd11, 5'd0);
      want("post_fire", WEN, 4'hF);
      want("post_gpr11", RS, 0);
      want("post_ret", RET, 0);
      tick();
      bus.mem_stall = 1'b0;
      rd_at(5'd12, 5'd0);
      want("post_hold_wen", WEN, 0);
      want("post_gpr12", RS, 32'h1212_1212);
      want("post_ret1", RET, 1);
      tick();
      bubble();
      rd_at(5'd5, 5'd7);
      want("post_gpr5", RS, 0);
      want("post_gpr7", RT, 0);
      tick();

      // randomized traffic against a reference model
      resetn = 1'b0;
      bubble();
      tick();
      resetn = 1'b1;
      for (int k = 0; k < 32; k++) mgpr[k] = 32'h0;
      mcnt  = 32'h0;
      mcomm = 1'b0;
      pstl  = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (!pstl) begin
            rmr   = 1'($urandom_range(0, 1));
            rrw   = ($urandom_range(0, 3) != 0);
            rbe   = 4'($urandom_range(0, 15));
            rrd   = 5'($urandom_range(0, 7));
            rmd   = $urandom;
            red   = $urandom;
            rrt   = $urandom;
            rcd   = 5'($urandom_range(0, 31));
            rcw   = ($urandom_range(0, 3) == 0);
            rinst = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         end
         stl = ($urandom_range(0, 2) == 0);
         rsa = 5'($urandom_range(0, 7));
         drive(rmr, rrw, rbe, rrd, rmd, red, rrt, rcd, rcw, rinst, stl);
         rd_at(rsa, rrd);
         fire = ~mcomm;
         base = rmr ? rmd : red;
         for (int l = 0; l < 4; l++) wd[8*l +: 8] = rbe[l] ? base[8*l +: 8] : rrt[8*l +: 8];
         wr   = fire && rrw && rrd != 0 && rbe != 0;
         ers  = (rsa == 0) ? 32'h0 : (wr && rsa == rrd) ? wd : mgpr[rsa];
         want($sformatf("rnd%0d_rs", c), RS, ers);
         want($sformatf("rnd%0d_rt", c), RT, (rrd == 0) ? 32'h0 : wr ? wd : mgpr[rrd]);
         want($sformatf("rnd%0d_wen", c), WEN, wr ? {28'h0, rbe} : 32'h0);
         want($sformatf("rnd%0d_wdat", c), WDAT, wd);
         want($sformatf("rnd%0d_cp0", c), CPW, {31'h0, fire & rcw});
         want($sformatf("rnd%0d_ret", c), RET, mcnt);
         tick();
         if (wr) mgpr[rrd] = wd;
         if (fire && rinst != 0) mcnt = mcnt + 1;
         mcomm = stl;
         pstl  = stl;
      end

      // counter wrap from all-ones
      bubble();
      force dut.cnt = 32'hFFFF_FFFF;
      #1;
      release dut.cnt;
      want("wrap_pre", RET, 32'hFFFF_FFFF);
      tick();
      drive(0, 0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 32'hA, 0);
      want("wrap_at", RET, 32'hFFFF_FFFF);
      tick();
      bubble();
      want("wrap_post", RET, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
